// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, data word and memory arbiter FSM states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache single-word requests onto one RAM port with a registered grant.
// Optional ARB_RR_EN: round-robin between caches when both request; otherwise dcache has fixed priority.
import cpu_types_pkg::*;

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_wait,
    output logic [DATA_W-1:0] i_load,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_store,
    output logic              d_wait,
    output logic [DATA_W-1:0] d_load,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic [1:0]        ram_state,
    output logic              err
);

    arb_state_t state;
    ramstate_t  rstate;
    logic       d_req;

    assign rstate = ramstate_t'(ram_state);
    assign d_req  = d_ren | d_wen;

`ifdef ARB_RR_EN
    logic last_d;
`endif

    // Grant is taken from IDLE only; completion or a dropped request returns to IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
`ifdef ARB_RR_EN
            last_d <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ARB_RR_EN
                    if (d_req && i_ren)
                        state <= last_d ? IGNT : DGNT;
                    else if (d_req)
                        state <= DGNT;
                    else if (i_ren)
                        state <= IGNT;
`else
                    if (d_req)
                        state <= DGNT;
                    else if (i_ren)
                        state <= IGNT;
`endif
                end
                IGNT: begin
                    if (!i_ren) begin
                        state <= IDLE;
                    end else if (rstate == ACCESS) begin
                        state <= IDLE;
`ifdef ARB_RR_EN
                        last_d <= 1'b0;
`endif
                    end
                end
                DGNT: begin
                    if (!d_req) begin
                        state <= IDLE;
                    end else if (rstate == ACCESS) begin
                        state <= IDLE;
`ifdef ARB_RR_EN
                        last_d <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        i_wait    = 1'b1;
        d_wait    = 1'b1;
        i_load    = '0;
        d_load    = '0;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        err       = 1'b0;
        case (state)
            IGNT: begin
                ram_addr = i_addr;
                if (i_ren) begin
                    ram_ren = 1'b1;
                    if (rstate == ACCESS) begin
                        i_wait = 1'b0;
                        i_load = ram_load;
                    end
                    err = (rstate == ERROR);
                end
            end
            DGNT: begin
                ram_addr = d_addr;
                // A write wins over a simultaneous read request.
                if (d_wen) begin
                    ram_wen   = 1'b1;
                    ram_store = d_store;
                end else if (d_ren) begin
                    ram_ren = 1'b1;
                end
                if (d_req) begin
                    if (rstate == ACCESS) begin
                        d_wait = 1'b0;
                        d_load = ram_load;
                    end
                    err = (rstate == ERROR);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against an owner-level model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        i_ren, d_ren, d_wen;
    logic [31:0] i_addr, d_addr, d_store, ram_load;
    logic [1:0]  ram_state;
    logic        i_wait, d_wait, ram_ren, ram_wen, err;
    logic [31:0] i_load, d_load, ram_addr, ram_store;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which cache owns the RAM port (0 none, 1 icache, 2 dcache) and who finished last.
    int owner = 0;
    bit last_d = 1'b0;
    logic exp_iw, exp_dw;
    logic obs_iw, obs_dw;
    logic [31:0] obs_addr;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_ren(i_ren), .i_addr(i_addr), .i_wait(i_wait), .i_load(i_load),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
        .d_wait(d_wait), .d_load(d_load),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_state(ram_state),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_i_wait"}, {31'b0, i_wait}, 32'd1);
        chk({tag, "_d_wait"}, {31'b0, d_wait}, 32'd1);
        chk({tag, "_ram_ren"}, {31'b0, ram_ren}, 32'd0);
        chk({tag, "_ram_wen"}, {31'b0, ram_wen}, 32'd0);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_store"}, ram_store, 32'd0);
        chk({tag, "_i_load"}, i_load, 32'd0);
        chk({tag, "_d_load"}, d_load, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                          input logic [31:0] da, input logic [31:0] ds,
                          input logic [1:0] rs, input logic [31:0] rl);
        i_ren = ir; i_addr = ia; d_ren = dr; d_wen = dw; d_addr = da; d_store = ds;
        ram_state = rs; ram_load = rl;
    endtask

    // Called just after a falling edge with inputs applied; checks this cycle, then advances one clock.
    task automatic check_cycle(input string tag);
        logic e_iw, e_dw, e_rr, e_rw, e_err;
        logic [31:0] e_ra, e_rs, e_il, e_dl;
        int nxt;
        bit nxt_last;
        bit want_d;
        #1;
        e_iw = 1'b1; e_dw = 1'b1; e_rr = 1'b0; e_rw = 1'b0; e_err = 1'b0;
        e_ra = '0; e_rs = '0; e_il = '0; e_dl = '0;
        nxt = owner; nxt_last = last_d;
        want_d = d_ren | d_wen;
        if (owner == 0) begin
            if (want_d && i_ren) begin
`ifdef ARB_RR_EN
                nxt = last_d ? 1 : 2;
`else
                nxt = 2;
`endif
            end else if (want_d) nxt = 2;
            else if (i_ren) nxt = 1;
        end else if (owner == 1) begin
            e_ra = i_addr;
            if (!i_ren) nxt = 0;
            else begin
                e_rr = 1'b1;
                if (ram_state == 2'd2) begin
                    e_iw = 1'b0; e_il = ram_load; nxt = 0; nxt_last = 1'b0;
                end
                e_err = (ram_state == 2'd3);
            end
        end else begin
            e_ra = d_addr;
            if (!want_d) nxt = 0;
            else begin
                if (d_wen) begin e_rw = 1'b1; e_rs = d_store; end
                else e_rr = 1'b1;
                if (ram_state == 2'd2) begin
                    e_dw = 1'b0; e_dl = ram_load; nxt = 0; nxt_last = 1'b1;
                end
                e_err = (ram_state == 2'd3);
            end
        end
        chk({tag, "_i_wait"}, {31'b0, i_wait}, {31'b0, e_iw});
        chk({tag, "_d_wait"}, {31'b0, d_wait}, {31'b0, e_dw});
        chk({tag, "_ram_ren"}, {31'b0, ram_ren}, {31'b0, e_rr});
        chk({tag, "_ram_wen"}, {31'b0, ram_wen}, {31'b0, e_rw});
        if (e_rr || e_rw) chk({tag, "_ram_addr"}, ram_addr, e_ra);
        chk({tag, "_ram_store"}, ram_store, e_rs);
        chk({tag, "_i_load"}, i_load, e_il);
        chk({tag, "_d_load"}, d_load, e_dl);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, e_err});
        exp_iw = e_iw; exp_dw = e_dw;
        obs_iw = i_wait; obs_dw = d_wait; obs_addr = ram_addr;
        @(posedge CLK);
        owner = nxt; last_d = nxt_last;
        @(negedge CLK);
    endtask

    initial begin
        bit i_pend, d_pend;
        nRST = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 0);
        #1;
        check_reset_values("reset");
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        // icache read, RAM busy two cycles then access
        set_in(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
        check_cycle("t1_c0");
        check_cycle("t1_c1");
        chk("t1_addr", obs_addr, 32'h40);
        check_cycle("t1_c2");
        chk("t1_wait_c2", {31'b0, obs_iw}, 32'd1);
        set_in(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'hDEADBEEF);
        check_cycle("t1_c3");
        chk("t1_wait_c3", {31'b0, obs_iw}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check_cycle("t1_c4");

        // both request: dcache first, one idle, then icache
        set_in(1, 32'h0, 1, 0, 32'h100, 0, 2'd0, 0);
        check_cycle("t2_idle");
        check_cycle("t2_dg_free");
        chk("t2_first_addr", obs_addr, 32'h100);
        set_in(1, 32'h0, 1, 0, 32'h100, 0, 2'd2, 32'hA5A5_0001);
        check_cycle("t2_dg_acc");
        set_in(1, 32'h0, 0, 0, 0, 0, 2'd0, 0);
        check_cycle("t2_gap");
        set_in(1, 32'h0, 0, 0, 0, 0, 2'd2, 32'hA5A5_0002);
        check_cycle("t2_ig_acc");
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check_cycle("t2_end");

        // write has precedence over read
        set_in(0, 0, 1, 1, 32'h200, 32'h12345678, 2'd1, 0);
        check_cycle("t3_idle");
        check_cycle("t3_busy");
        set_in(0, 0, 1, 1, 32'h200, 32'h12345678, 2'd2, 0);
        check_cycle("t3_acc");
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check_cycle("t3_end");

        // RAM error then access during icache grant
        set_in(1, 32'h80, 0, 0, 0, 0, 2'd3, 0);
        check_cycle("t4_idle");
        check_cycle("t4_error");
        set_in(1, 32'h80, 0, 0, 0, 0, 2'd2, 32'hCAFE_F00D);
        check_cycle("t4_acc");
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check_cycle("t4_end");

        // async reset during a busy dcache grant
        set_in(0, 0, 1, 0, 32'h300, 0, 2'd1, 0);
        check_cycle("t5_idle");
        check_cycle("t5_busy");
        nRST = 1'b0;
        #1;
        check_reset_values("t5_rst");
        owner = 0; last_d = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        check_cycle("t5_rel");
        check_cycle("t5_regrant");
        set_in(0, 0, 1, 0, 32'h300, 0, 2'd2, 32'h0BAD_CAFE);
        check_cycle("t5_acc");
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 0);
        check_cycle("t5_end");

        // dcache abandons its request while RAM is busy
        set_in(0, 0, 1, 0, 32'h400, 0, 2'd1, 0);
        check_cycle("t6_idle");
        check_cycle("t6_busy");
        set_in(0, 0, 0, 0, 32'h400, 0, 2'd1, 0);
        check_cycle("t6_abort");
        chk("t6_dwait", {31'b0, obs_dw}, 32'd1);
        check_cycle("t6_after");

        // random traffic; caches hold requests until served, with rare aborts
        i_pend = 0; d_pend = 0;
        set_in(0, 0, 0, 0, 0, 0, 2'd0, 0);
        for (int k = 0; k < 400; k++) begin
            if (!i_pend && ($urandom % 3 == 0)) begin
                i_pend = 1; i_ren = 1; i_addr = $urandom & 32'hFFFF_FFFC;
            end else if (i_pend && ($urandom % 20 == 0)) begin
                i_pend = 0; i_ren = 0;
            end
            if (!d_pend && ($urandom % 3 == 0)) begin
                d_pend = 1; d_addr = $urandom & 32'hFFFF_FFFC; d_store = $urandom;
                case ($urandom % 3)
                    0: begin d_ren = 1; d_wen = 0; end
                    1: begin d_ren = 0; d_wen = 1; end
                    default: begin d_ren = 1; d_wen = 1; end
                endcase
            end else if (d_pend && ($urandom % 20 == 0)) begin
                d_pend = 0; d_ren = 0; d_wen = 0;
            end
            ram_state = 2'($urandom % 4);
            ram_load  = $urandom;
            check_cycle("rnd");
            if (!exp_iw) begin i_pend = 0; i_ren = 0; end
            if (!exp_dw) begin d_pend = 0; d_ren = 0; d_wen = 0; end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction cache and the data cache.
- Arbitrates their single-word miss/writeback requests onto one shared RAM port.
- Forwards the RAM handshake back to the granted cache; the other cache sees wait held high.
- Registered-grant FSM; one transaction in flight at a time.

Parameters:
- ADDR_W, 32, width of byte address on all ports
- DATA_W, 32, width of data word on all ports

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- i_ren  in  1  icache read request
- i_addr  in  ADDR_W  icache read address
- i_wait  out  1  icache stall; low for exactly the cycle i_load is valid
- i_load  out  DATA_W  instruction word returned to icache
- d_ren  in  1  dcache read request
- d_wen  in  1  dcache write request
- d_addr  in  ADDR_W  dcache address
- d_store  in  DATA_W  dcache write data
- d_wait  out  1  dcache stall; low for the completing cycle
- d_load  out  DATA_W  data word returned to dcache
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  DATA_W  RAM write data
- ram_load  in  DATA_W  RAM read data
- ram_state  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  one-cycle pulse when RAM reports ERROR

Behaviour:
- Reset values: state=IDLE, i_wait=1, d_wait=1, ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0, i_load=0, d_load=0, err=0.
- Combinational outputs (i_wait, d_wait, i_load, d_load, ram_*) depend on the registered state and the granted requester's live inputs.
- Caches hold request, address and data stable until their wait drops.
- States: IDLE, IGNT, DGNT.
- IDLE:
  - No RAM strobes; both waits high.
  - Next state DGNT if d_ren|d_wen; else IGNT if i_ren; else IDLE.
  - Grant is therefore registered: request in cycle N, RAM strobe in cycle N+1.
- DGNT:
  - ram_addr=d_addr.
  - d_wen has precedence over d_ren: if both high, ram_wen=1, ram_ren=0, ram_store=d_store.
  - Otherwise ram_ren=1.
- IGNT: ram_ren=1, ram_addr=i_addr.
- Completion (granted side, when ram_state==ACCESS):
  - Granted wait=0 that cycle; read data = ram_load; next state IDLE.
  - Minimum latency request-to-wait-low is 2 cycles; one mandatory IDLE cycle between back-to-back transactions.
- BUSY/FREE in a grant state: hold state, wait high.
- ERROR in a grant state: err=1 for that cycle, wait stays high, state held (request retried next cycle).
- Abort: if the granted requester drops its request mid-grant, the strobe drops combinationally and the next state is IDLE.
- The non-granted wait is always 1. i_load/d_load are 0 when the corresponding wait is 1.
- Asynchronous reset mid-transaction returns to IDLE immediately; the in-flight access is discarded.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: a 1-bit register last_d records the last completed grant (reset 0). When both caches request in IDLE, the side not last granted wins, giving round-robin.
- Undefined: fixed priority, dcache always wins.
- Single-requester behaviour is identical in both builds.

Decomposition:
- ramstate_t, word_t and the arbiter state enum arb_state_t belong in the shared package cpu_types_pkg.
- No sub-module: the FSM and muxing stay in one file.

Test Plan:
- i_ren=1, i_addr=0x40, RAM BUSY 2 cycles then ACCESS with ram_load=0xDEADBEEF -> ram_ren=1, ram_addr=0x40 from cycle 1; i_wait low exactly in cycle 3 with i_load=0xDEADBEEF; state IDLE in cycle 4.
- i_ren and d_ren both high, i_addr=0x0, d_addr=0x100 -> dcache served first (ram_addr=0x100); after its ACCESS, one IDLE cycle, then icache served (ram_addr=0x0); under ARB_RR_EN with last_d=1, the icache is served first instead.
- d_wen=1, d_ren=1, d_addr=0x200, d_store=0x12345678 -> ram_wen=1, ram_ren=0, ram_store=0x12345678; d_wait low on ACCESS.
- RAM returns ERROR for 1 cycle then ACCESS during an icache grant -> err pulses once; i_wait remains high through the ERROR cycle and goes low on ACCESS.
- nRST asserted during DGNT with RAM BUSY -> all outputs at reset values immediately; after release with d_ren still high, a fresh grant occurs 1 cycle later.
- Granted dcache drops d_ren while RAM is BUSY -> ram_ren falls the same cycle, state returns to IDLE, d_wait never goes low.
